// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage; owns the PC, fetches words over req/gnt/valid,
// and hands one instruction plus its PC to decode through a valid/ready register.
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   o_imem_req/o_imem_addr        fetch request (held until i_imem_gnt) and word address
//   i_imem_gnt/valid/rdata        memory accept, read-data strobe, read data
//   i_redirect/i_redirect_pc      one-cycle restart of fetch at a new target
//   o_inst_valid/i_dec_ready      decode handshake for o_inst_data/o_inst_pc
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] target;
  assign target       = i_redirect_pc & 32'hFFFF_FFFC;
  assign o_imem_req   = state_q == REQ;
  assign o_imem_addr  = pc_q;
  assign o_inst_valid = inst_valid_q;
  assign o_inst_data  = inst_data_q;
  assign o_inst_pc    = inst_pc_q;
  // drop marks the single response still owed by memory as wrong-path
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    if (i_redirect) begin
      pc_d = target;
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          state_d = i_imem_gnt ? WAIT : REQ;
          drop_d  = i_imem_gnt;
        end
        WAIT: begin
          state_d = i_imem_valid ? REQ : WAIT;
          drop_d  = !i_imem_valid;
        end
        default: begin
          state_d      = REQ;
          inst_valid_d = 1'b0;
          inst_data_d  = NOP_INST;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = i_imem_gnt ? WAIT : REQ;
        WAIT: begin
          if (i_imem_valid && drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (i_imem_valid) begin
            inst_valid_d = 1'b1;
            inst_data_d  = i_imem_rdata;
            inst_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = HOLD;
          end
        end
        default: begin
          if (i_dec_ready) begin
            inst_valid_d = 1'b0;
            inst_data_d  = NOP_INST;
            state_d      = REQ;
          end
        end
      endcase
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= NOP_INST;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end
endmodule
